// File: rtl/tdm_mux8_if.sv
// Purpose: frame-in / beat-out handshake bundle for the eight-lane TDM multiplexer.
// Latency: none; this is wiring only.
// Backpressure: in_valid/in_ready on the frame side, out_valid/out_ready on the beat side.
//
// Ports carried:
//   in_valid, in_data[8*LANE_W], lane_en[8]  -> frame offered by upstream
//   in_ready                                 <- frame taken this cycle
//   out_valid, out_data[LANE_W], out_sel[3]  <- current beat and its lane index
//   out_last                                 <- beat is the highest enabled lane
//   out_ready                                -> downstream takes the beat
// Modport slave is the multiplexer's view; master is the surrounding logic's view.
interface tdm_mux8_if #(
    parameter int LANE_W = 1
);
    logic                  in_valid;
    logic                  in_ready;
    logic [8*LANE_W-1:0]   in_data;
    logic [7:0]            lane_en;
    logic                  out_valid;
    logic                  out_ready;
    logic [LANE_W-1:0]     out_data;
    logic [2:0]            out_sel;
    logic                  out_last;

    modport slave (
        input  in_valid, in_data, lane_en, out_ready,
        output in_ready, out_valid, out_data, out_sel, out_last
    );

    modport master (
        output in_valid, in_data, lane_en, out_ready,
        input  in_ready, out_valid, out_data, out_sel, out_last
    );
endinterface

// File: rtl/tdm_mux8.sv
// Purpose: serialises the enabled lanes of an eight-lane frame, ascending index, tagged with lane number.
// Latency: first beat valid the cycle after the frame is accepted; one beat per cycle thereafter.
// Backpressure: out_ready low freezes the current beat; a new frame is taken only when idle or on the last beat.
//
// Ports:
//   clk, rst_n  : single rising-edge clock, asynchronous active-low reset
//   bus         : tdm_mux8_if.slave (frame input, beat output, handshakes)
//   frame_cnt   : count of completed frames, wraps 255 -> 0
module tdm_mux8 #(
    parameter int LANE_W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    tdm_mux8_if.slave    bus,
    output logic [7:0]   frame_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t              state_q;
    logic [8*LANE_W-1:0] frame_q;
    logic [7:0]          mask_q;
    logic [2:0]          sel_q;
    logic [7:0]          cnt_q;

    logic [7:0]          above;
    logic                sending;
    logic                last;
    logic                beat_done;
    logic                accept;

    // Index of the lowest set bit; callers only use it on a nonzero mask.
    function automatic logic [2:0] lowest_set(input logic [7:0] m);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

    assign sending   = (state_q == SEND);
    // Enabled lanes strictly above the current one; empty means this beat closes the frame.
    assign above     = mask_q & (8'hFE << sel_q);
    assign last      = sending && (above == 8'h00);
    assign beat_done = sending && bus.out_ready;
    // The last beat frees the frame register on the same edge, so a waiting frame loads bubble-free.
    assign accept    = bus.in_valid && bus.in_ready;

    assign bus.in_ready  = !sending || (beat_done && last);
    assign bus.out_valid = sending;
    assign bus.out_sel   = sel_q;
    assign bus.out_last  = last;
    assign bus.out_data  = sending ? frame_q[sel_q*LANE_W +: LANE_W] : '0;
    assign frame_cnt     = cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            frame_q <= '0;
            mask_q  <= 8'h00;
            sel_q   <= 3'd0;
            cnt_q   <= 8'h00;
        end else begin
            if (beat_done && last) begin
                cnt_q <= cnt_q + 8'd1;
            end

            if (accept) begin
                frame_q <= bus.in_data;
                mask_q  <= bus.lane_en;
                if (bus.lane_en != 8'h00) begin
                    state_q <= SEND;
                    sel_q   <= lowest_set(bus.lane_en);
                end else begin
                    // Empty frame: swallowed, nothing emitted, not counted.
                    state_q <= IDLE;
                end
            end else if (beat_done) begin
                if (last) begin
                    state_q <= IDLE;
                end else begin
                    // Jump straight to the next enabled lane; disabled lanes cost no cycles.
                    sel_q <= lowest_set(above);
                end
            end
        end
    end

endmodule

// File: tb/tb_tdm_mux8.sv
module tb_tdm_mux8;

    logic       clk;
    logic       rst_n;
    logic [7:0] frame_cnt;
    int         vectors;
    int         miscompares;

    tdm_mux8_if #(.LANE_W(1)) bus ();

    tdm_mux8 #(.LANE_W(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; afterwards signals are sampled 1 time unit past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check the beat currently presented, then let it transfer (out_ready must be 1).
    task automatic beat(input string tag, input logic [2:0] sel, input logic dat, input logic lst);
        chk({tag, " valid"}, bus.out_valid, 1'b1);
        chk({tag, " sel"},   bus.out_sel,   sel);
        chk({tag, " data"},  bus.out_data,  dat);
        chk({tag, " last"},  bus.out_last,  lst);
        step();
    endtask

    task automatic offer(input logic [7:0] dat, input logic [7:0] en);
        bus.in_valid = 1'b1;
        bus.in_data  = dat;
        bus.lane_en  = en;
    endtask

    initial begin
        logic [7:0] d;
        vectors     = 0;
        miscompares = 0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.lane_en   = 8'h00;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;

        // Reset state
        step();
        chk("rst out_valid", bus.out_valid, 1'b0);
        chk("rst out_data",  bus.out_data,  1'b0);
        chk("rst out_last",  bus.out_last,  1'b0);
        chk("rst out_sel",   bus.out_sel,   3'd0);
        chk("rst in_ready",  bus.in_ready,  1'b1);
        chk("rst frame_cnt", frame_cnt,     8'd0);
        rst_n = 1'b1;
        step();

        // Full frame, all lanes: data bits 1,0,1,0,0,1,0,1
        d = 8'b1010_0101;
        offer(d, 8'hFF);
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            beat("full", 3'(i), d[i], (i == 7));
        end
        chk("full idle valid", bus.out_valid, 1'b0);
        chk("full frame_cnt",  frame_cnt,     8'd1);

        // Sparse mask: lanes 1 and 7 only
        offer(8'b1000_0000, 8'b1000_0010);
        step();
        bus.in_valid = 1'b0;
        beat("sparse0", 3'd1, 1'b0, 1'b0);
        beat("sparse1", 3'd7, 1'b1, 1'b1);
        chk("sparse idle valid", bus.out_valid, 1'b0);
        chk("sparse frame_cnt",  frame_cnt,     8'd2);

        // Backpressure: out_ready 1,0,0,1 then held high
        d = 8'h3C;
        offer(d, 8'hFF);
        step();
        bus.in_valid = 1'b0;
        beat("bp0", 3'd0, d[0], 1'b0);
        bus.out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("bp stall valid",    bus.out_valid, 1'b1);
            chk("bp stall sel",      bus.out_sel,   3'd1);
            chk("bp stall data",     bus.out_data,  d[1]);
            chk("bp stall last",     bus.out_last,  1'b0);
            chk("bp stall in_ready", bus.in_ready,  1'b0);
            step();
        end
        bus.out_ready = 1'b1;
        for (int i = 1; i < 8; i++) begin
            beat("bp", 3'(i), d[i], (i == 7));
        end
        chk("bp idle valid", bus.out_valid, 1'b0);
        chk("bp frame_cnt",  frame_cnt,     8'd3);

        // Back-to-back: frame A lanes 0,2 of 0x0F; frame B lanes 4,5 of 0xF0 waiting
        offer(8'h0F, 8'h05);
        step();
        offer(8'hF0, 8'h30);
        chk("b2b first in_ready", bus.in_ready, 1'b0);
        beat("b2b a0", 3'd0, 1'b1, 1'b0);
        chk("b2b last in_ready", bus.in_ready, 1'b1);
        beat("b2b a2", 3'd2, 1'b1, 1'b1);
        bus.in_valid = 1'b0;
        chk("b2b cnt after a", frame_cnt, 8'd4);
        beat("b2b b4", 3'd4, 1'b1, 1'b0);
        beat("b2b b5", 3'd5, 1'b1, 1'b1);
        chk("b2b idle valid", bus.out_valid, 1'b0);
        chk("b2b frame_cnt",  frame_cnt,     8'd5);

        // Empty mask: accepted, nothing emitted, not counted
        offer(8'hFF, 8'h00);
        chk("empty in_ready", bus.in_ready, 1'b1);
        step();
        bus.in_valid = 1'b0;
        chk("empty valid",     bus.out_valid, 1'b0);
        chk("empty frame_cnt", frame_cnt,     8'd5);
        step();
        chk("empty valid2",    bus.out_valid, 1'b0);

        // Reset mid-frame after three beats
        offer(8'hFF, 8'hFF);
        step();
        bus.in_valid = 1'b0;
        beat("mid0", 3'd0, 1'b1, 1'b0);
        beat("mid1", 3'd1, 1'b1, 1'b0);
        beat("mid2", 3'd2, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst valid",     bus.out_valid, 1'b0);
        chk("midrst frame_cnt", frame_cnt,     8'd0);
        chk("midrst sel",       bus.out_sel,   3'd0);
        step();
        rst_n = 1'b1;
        offer(8'h10, 8'b0101_0000);
        step();
        bus.in_valid = 1'b0;
        beat("post4", 3'd4, 1'b1, 1'b0);
        beat("post6", 3'd6, 1'b0, 1'b1);
        chk("post frame_cnt", frame_cnt, 8'd1);

        // Wrap: 256 one-lane frames back to back from a fresh reset
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        offer(8'h80, 8'h80);
        step();
        for (int i = 0; i < 255; i++) begin
            step();
        end
        chk("wrap cnt 255",   frame_cnt,     8'd255);
        chk("wrap valid",     bus.out_valid, 1'b1);
        chk("wrap sel",       bus.out_sel,   3'd7);
        bus.in_valid = 1'b0;
        step();
        chk("wrap cnt 0",     frame_cnt,     8'd0);
        chk("wrap idle",      bus.out_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
